// File: rtl/afu_port_rst_seq_if.sv
// Per-port reset request, TX A observation and reset/status bundle for afu_port_rst_seq.
// The master drives requests and observed handshakes; the slave is the sequencer.
interface afu_port_rst_seq_if #(
    parameter int NUM_PORTS = 1
);
    logic [NUM_PORTS-1:0] port_rst_n_in;
    logic [NUM_PORTS-1:0] tx_tvalid;
    logic [NUM_PORTS-1:0] tx_tready;
    logic [NUM_PORTS-1:0] tx_tlast;
    logic [NUM_PORTS-1:0] timeout_clr;
    logic [NUM_PORTS-1:0] afu_port_rst_n;
    logic [NUM_PORTS-1:0] tx_block;
    logic [NUM_PORTS-1:0] port_rdy;
    logic [NUM_PORTS-1:0] drain_timeout;

    modport master (
        output port_rst_n_in, tx_tvalid, tx_tready, tx_tlast, timeout_clr,
        input  afu_port_rst_n, tx_block, port_rdy, drain_timeout
    );

    modport slave (
        input  port_rst_n_in, tx_tvalid, tx_tready, tx_tlast, timeout_clr,
        output afu_port_rst_n, tx_block, port_rdy, drain_timeout
    );
endinterface

// File: rtl/afu_port_rst_seq.sv
// Per-port AFU reset sequencer: request synchronizer, release hold-off and
// drain of any open TX A packet (bounded by a timeout) before reset is applied.
module afu_port_rst_seq #(
    parameter int NUM_PORTS     = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int HOLD_CYCLES   = 16,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    afu_port_rst_seq_if.slave  bus
);
    localparam int CNT_MAX = (HOLD_CYCLES > DRAIN_TIMEOUT) ? HOLD_CYCLES : DRAIN_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_HOLD,
        ST_RUN,
        ST_DRAIN
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q  [NUM_PORTS];
    state_t                 state_q [NUM_PORTS];
    logic [CW-1:0]          cnt_q   [NUM_PORTS];

    logic [NUM_PORTS-1:0] req_n;
    logic [NUM_PORTS-1:0] beat;
    logic [NUM_PORTS-1:0] in_pkt_q;
    logic [NUM_PORTS-1:0] afu_rst_n_q;
    logic [NUM_PORTS-1:0] tx_block_q;
    logic [NUM_PORTS-1:0] port_rdy_q;
    logic [NUM_PORTS-1:0] timeout_q;

    assign beat = bus.tx_tvalid & bus.tx_tready;

    always_comb begin
        req_n = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            req_n[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                sync_q[i]  <= '0;
                state_q[i] <= ST_RESET;
                cnt_q[i]   <= '0;
            end
            in_pkt_q    <= '0;
            afu_rst_n_q <= '0;
            tx_block_q  <= '1;
            port_rdy_q  <= '0;
            timeout_q   <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.port_rst_n_in[i]};

                if (state_q[i] == ST_RESET || state_q[i] == ST_HOLD) begin
                    in_pkt_q[i] <= 1'b0;
                end else if (beat[i]) begin
                    in_pkt_q[i] <= ~bus.tx_tlast[i];
                end

                // Clear first so a timeout set below in the same cycle takes priority.
                if (bus.timeout_clr[i]) begin
                    timeout_q[i] <= 1'b0;
                end

                case (state_q[i])
                    ST_RESET: begin
                        if (req_n[i]) begin
                            state_q[i] <= ST_HOLD;
                            cnt_q[i]   <= HOLD_LOAD;
                        end
                    end
                    ST_HOLD: begin
                        if (!req_n[i]) begin
                            state_q[i] <= ST_RESET;
                        end else if (cnt_q[i] == '0) begin
                            state_q[i]     <= ST_RUN;
                            afu_rst_n_q[i] <= 1'b1;
                            tx_block_q[i]  <= 1'b0;
                            port_rdy_q[i]  <= 1'b1;
                        end else begin
                            cnt_q[i] <= cnt_q[i] - CNT_ONE;
                        end
                    end
                    ST_RUN: begin
                        if (!req_n[i]) begin
                            state_q[i]    <= ST_DRAIN;
                            cnt_q[i]      <= DRAIN_LOAD;
                            tx_block_q[i] <= 1'b1;
                            port_rdy_q[i] <= 1'b0;
                        end
                    end
                    ST_DRAIN: begin
                        // Request changes are ignored here: once draining, reset is committed.
                        if (!in_pkt_q[i] || cnt_q[i] == '0) begin
                            state_q[i]     <= ST_RESET;
                            afu_rst_n_q[i] <= 1'b0;
                            if (in_pkt_q[i]) begin
                                timeout_q[i] <= 1'b1;
                            end
                        end else begin
                            cnt_q[i] <= cnt_q[i] - CNT_ONE;
                        end
                    end
                    default: begin
                        state_q[i]     <= ST_RESET;
                        afu_rst_n_q[i] <= 1'b0;
                        tx_block_q[i]  <= 1'b1;
                        port_rdy_q[i]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.afu_port_rst_n = afu_rst_n_q;
    assign bus.tx_block       = tx_block_q;
    assign bus.port_rdy       = port_rdy_q;
    assign bus.drain_timeout  = timeout_q;
endmodule

// File: tb/tb_afu_port_rst_seq.sv
// Bench for afu_port_rst_seq: two 4-lane instances (drain timeouts 1024 and 8) share
// stimulus; directed scenarios plus random traffic against a timing-rule model.
module tb_afu_port_rst_seq;
    localparam int NP    = 4;
    localparam int SYNC  = 2;
    localparam int HOLD  = 16;
    localparam int DT_A  = 1024;
    localparam int DT_B  = 8;
    localparam int RISE  = SYNC + HOLD + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NP-1:0] p_in = '1, vld = '0, rdy = '0, lst = '0, clr = '0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    afu_port_rst_seq_if #(.NUM_PORTS(NP)) ifa ();
    afu_port_rst_seq_if #(.NUM_PORTS(NP)) ifb ();

    assign ifa.port_rst_n_in = p_in;
    assign ifa.tx_tvalid     = vld;
    assign ifa.tx_tready     = rdy;
    assign ifa.tx_tlast      = lst;
    assign ifa.timeout_clr   = clr;
    assign ifb.port_rst_n_in = p_in;
    assign ifb.tx_tvalid     = vld;
    assign ifb.tx_tready     = rdy;
    assign ifb.tx_tlast      = lst;
    assign ifb.timeout_clr   = clr;

    afu_port_rst_seq #(.NUM_PORTS(NP), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD),
                       .DRAIN_TIMEOUT(DT_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    afu_port_rst_seq #(.NUM_PORTS(NP), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD),
                       .DRAIN_TIMEOUT(DT_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    logic [NP-1:0] act_afu [2], act_blk [2], act_rdy [2], act_to [2];
    assign act_afu[0] = ifa.afu_port_rst_n;
    assign act_blk[0] = ifa.tx_block;
    assign act_rdy[0] = ifa.port_rdy;
    assign act_to[0]  = ifa.drain_timeout;
    assign act_afu[1] = ifb.afu_port_rst_n;
    assign act_blk[1] = ifb.tx_block;
    assign act_rdy[1] = ifb.port_rdy;
    assign act_to[1]  = ifb.drain_timeout;

    // Reference: reset is released once the synchronized request has been seen high on
    // HOLD+1 consecutive edges; a drop while up starts a drain with an absolute deadline.
    bit     m_hist [2][NP][SYNC];
    bit     m_up   [2][NP];
    bit     m_drn  [2][NP];
    bit     m_pkt  [2][NP];
    bit     m_to   [2][NP];
    int     m_high [2][NP];
    longint m_dead [2][NP];
    longint cyc = 0;
    logic [NP-1:0] e_afu [2], e_blk [2], e_rdy [2], e_to [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int l = 0; l < NP; l++) begin
                    m_up[d][l] = 0; m_drn[d][l] = 0; m_pkt[d][l] = 0;
                    m_to[d][l] = 0; m_high[d][l] = 0;
                    for (int s = 0; s < SYNC; s++) m_hist[d][l][s] = 0;
                end
            end
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                for (int l = 0; l < NP; l++) begin
                    bit req, was_open, set_to;
                    req      = m_hist[d][l][SYNC-1];
                    was_open = m_pkt[d][l];
                    set_to   = 0;
                    if (!m_up[d][l]) m_pkt[d][l] = 0;
                    else if (vld[l] && rdy[l]) m_pkt[d][l] = !lst[l];
                    if (!m_up[d][l]) begin
                        m_high[d][l] = req ? m_high[d][l] + 1 : 0;
                        if (m_high[d][l] == HOLD + 1) begin
                            m_up[d][l] = 1;
                            m_high[d][l] = 0;
                        end
                    end else if (!m_drn[d][l]) begin
                        if (!req) begin
                            m_drn[d][l]  = 1;
                            m_dead[d][l] = cyc + ((d == 0) ? DT_A : DT_B);
                        end
                    end else if (!was_open || cyc == m_dead[d][l]) begin
                        set_to      = was_open;
                        m_up[d][l]  = 0;
                        m_drn[d][l] = 0;
                    end
                    if (set_to) m_to[d][l] = 1;
                    else if (clr[l]) m_to[d][l] = 0;
                    for (int s = SYNC - 1; s > 0; s--) m_hist[d][l][s] = m_hist[d][l][s-1];
                    m_hist[d][l][0] = p_in[l];
                end
            end
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            e_afu[d] = '0; e_blk[d] = '0; e_rdy[d] = '0; e_to[d] = '0;
            for (int l = 0; l < NP; l++) begin
                e_afu[d][l] = m_up[d][l];
                e_blk[d][l] = !m_up[d][l] || m_drn[d][l];
                e_rdy[d][l] = m_up[d][l] && !m_drn[d][l];
                e_to[d][l]  = m_to[d][l];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int first [2];
        logic [NP-1:0] val [2];
        logic [NP-1:0] rv [2];
        rst_n = 1'b0; p_in = '1; vld = '0; rdy = '0; lst = '0; clr = '0;
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (act_afu[d] !== '0) begin n_bad++; $display("FAIL reset_afu dut%0d: got %b want 0000", d, act_afu[d]); end
            n_cmp++; if (act_blk[d] !== '1) begin n_bad++; $display("FAIL reset_blk dut%0d: got %b want 1111", d, act_blk[d]); end
            n_cmp++; if (act_rdy[d] !== '0) begin n_bad++; $display("FAIL reset_rdy dut%0d: got %b want 0000", d, act_rdy[d]); end
            n_cmp++; if (act_to[d] !== '0) begin n_bad++; $display("FAIL reset_to dut%0d: got %b want 0000", d, act_to[d]); end
            first[d] = -1;
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                if (first[d] < 0 && act_afu[d] !== '0) begin
                    first[d] = k; val[d] = act_afu[d]; rv[d] = act_rdy[d];
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (first[d] != RISE) begin n_bad++; $display("FAIL release_edge dut%0d: got %0d want %0d", d, first[d], RISE); end
            n_cmp++; if (val[d] !== '1 || rv[d] !== '1) begin n_bad++; $display("FAIL release_lanes dut%0d: got afu %b rdy %b want 1111", d, val[d], rv[d]); end
        end
    endtask

    task automatic test_idle_assert();
        p_in[0] = 1'b0;
        step(); step();
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if ({act_afu[d][0], act_blk[d][0], act_rdy[d][0]} !== 3'b101) begin n_bad++; $display("FAIL idle_edge2 dut%0d: got %b want 101", d, {act_afu[d][0], act_blk[d][0], act_rdy[d][0]}); end
        end
        step();
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if ({act_afu[d][0], act_blk[d][0], act_rdy[d][0]} !== 3'b110) begin n_bad++; $display("FAIL idle_edge3 dut%0d: got %b want 110", d, {act_afu[d][0], act_blk[d][0], act_rdy[d][0]}); end
        end
        step();
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if ({act_afu[d][0], act_blk[d][0], act_rdy[d][0], act_to[d][0]} !== 4'b0100) begin n_bad++; $display("FAIL idle_edge4 dut%0d: got %b want 0100", d, {act_afu[d][0], act_blk[d][0], act_rdy[d][0], act_to[d][0]}); end
            n_cmp++; if (act_rdy[d][3:1] !== 3'b111) begin n_bad++; $display("FAIL idle_others dut%0d: got %b want 111", d, act_rdy[d][3:1]); end
        end
        p_in[0] = 1'b1;
        repeat (RISE - 1) step();
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (act_afu[d][0] !== 1'b0) begin n_bad++; $display("FAIL idle_rerelease_early dut%0d: got %b want 0", d, act_afu[d][0]); end
        end
        step();
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if ({act_afu[d][0], act_rdy[d][0]} !== 2'b11) begin n_bad++; $display("FAIL idle_rerelease dut%0d: got %b want 11", d, {act_afu[d][0], act_rdy[d][0]}); end
        end
    endtask

    task automatic test_open_packet();
        vld[1] = 1'b1; rdy[1] = 1'b1; lst[1] = 1'b0;
        step();
        vld[1] = 1'b0; p_in[1] = 1'b0;
        repeat (3) step();
        vld[1] = 1'b1;
        step(); step();
        lst[1] = 1'b1;
        step();
        vld[1] = 1'b0; lst[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if ({act_afu[d][1], act_blk[d][1], act_rdy[d][1]} !== 3'b110) begin n_bad++; $display("FAIL pkt_at_tlast dut%0d: got %b want 110", d, {act_afu[d][1], act_blk[d][1], act_rdy[d][1]}); end
        end
        step();
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if ({act_afu[d][1], act_blk[d][1], act_to[d][1]} !== 3'b010) begin n_bad++; $display("FAIL pkt_after_tlast dut%0d: got %b want 010", d, {act_afu[d][1], act_blk[d][1], act_to[d][1]}); end
        end
        rdy = '0; p_in[1] = 1'b1;
        repeat (RISE + 1) step();
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (act_rdy[d][1] !== 1'b1) begin n_bad++; $display("FAIL pkt_recover dut%0d: got %b want 1", d, act_rdy[d][1]); end
        end
    endtask

    task automatic test_stuck_packet();
        vld[2] = 1'b1; rdy[2] = 1'b1; lst[2] = 1'b0;
        step();
        vld[2] = 1'b0; p_in[2] = 1'b0;
        repeat (3 + DT_B - 1) step();
        n_cmp++; if ({act_afu[1][2], act_to[1][2]} !== 2'b10) begin n_bad++; $display("FAIL stuck_before dut1: got %b want 10", {act_afu[1][2], act_to[1][2]}); end
        clr[2] = 1'b1;
        step();
        clr[2] = 1'b0;
        n_cmp++; if ({act_afu[1][2], act_to[1][2]} !== 2'b01) begin n_bad++; $display("FAIL stuck_timeout dut1: got %b want 01", {act_afu[1][2], act_to[1][2]}); end
        n_cmp++; if ({act_afu[0][2], act_blk[0][2], act_to[0][2]} !== 3'b110) begin n_bad++; $display("FAIL stuck_long_drain dut0: got %b want 110", {act_afu[0][2], act_blk[0][2], act_to[0][2]}); end
        repeat (4) step();
        n_cmp++; if (act_to[1][2] !== 1'b1) begin n_bad++; $display("FAIL stuck_sticky dut1: got %b want 1", act_to[1][2]); end
        clr[2] = 1'b1;
        step();
        clr[2] = 1'b0;
        n_cmp++; if (act_to[1][2] !== 1'b0) begin n_bad++; $display("FAIL stuck_clear dut1: got %b want 0", act_to[1][2]); end
        vld[2] = 1'b1; lst[2] = 1'b1;
        step();
        vld[2] = 1'b0; lst[2] = 1'b0;
        step();
        n_cmp++; if ({act_afu[0][2], act_to[0][2]} !== 2'b00) begin n_bad++; $display("FAIL stuck_close dut0: got %b want 00", {act_afu[0][2], act_to[0][2]}); end
        rdy = '0; p_in[2] = 1'b1;
        repeat (RISE + 1) step();
    endtask

    task automatic test_hold_glitch();
        int first [2];
        bit rose [2];
        p_in[3] = 1'b0;
        repeat (6) step();
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (act_afu[d][3] !== 1'b0) begin n_bad++; $display("FAIL glitch_pre dut%0d: got %b want 0", d, act_afu[d][3]); end
            rose[d] = 0; first[d] = -1;
        end
        p_in[3] = 1'b1;
        repeat (5) step();
        p_in[3] = 1'b0;
        repeat (25) begin
            step();
            for (int d = 0; d < 2; d++) if (act_afu[d][3] !== 1'b0) rose[d] = 1;
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (rose[d] != 0) begin n_bad++; $display("FAIL glitch_no_rise dut%0d: got 1 want 0", d); end
        end
        p_in[3] = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            for (int d = 0; d < 2; d++) if (first[d] < 0 && act_afu[d][3] === 1'b1) first[d] = k;
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (first[d] != RISE) begin n_bad++; $display("FAIL glitch_full_hold dut%0d: got %0d want %0d", d, first[d], RISE); end
        end
    endtask

    task automatic test_multi_lane();
        int drop_at [NP] = '{0, 3, 5, 7};
        int rel_at  [NP] = '{24, 26, 28, 30};
        for (int s = 0; s < 60; s++) begin
            for (int l = 0; l < NP; l++) begin
                if (s == drop_at[l]) p_in[l] = 1'b0;
                if (s == rel_at[l])  p_in[l] = 1'b1;
            end
            vld = '0; rdy = '0; lst = '0;
            if (s == 0) begin vld[2] = 1'b1; rdy[2] = 1'b1; end
            if (s == 20) begin
                n_cmp++; if ({act_afu[0][2], act_blk[0][2], act_to[1][2]} !== 3'b111) begin n_bad++; $display("FAIL multi_mid_drain: got %b want 111", {act_afu[0][2], act_blk[0][2], act_to[1][2]}); end
                #1 rst_n = 1'b0;
                #1;
                for (int d = 0; d < 2; d++) begin
                    n_cmp++; if ({act_afu[d], act_blk[d], act_rdy[d], act_to[d]} !== {4'b0000, 4'b1111, 4'b0000, 4'b0000}) begin
                        n_bad++; $display("FAIL multi_async_rst dut%0d: got %h want 0f00", d, {act_afu[d], act_blk[d], act_rdy[d], act_to[d]});
                    end
                end
                rst_n = 1'b1;
            end
            step();
            for (int d = 0; d < 2; d++) begin
                n_cmp++; if ({act_afu[d], act_blk[d], act_rdy[d], act_to[d]} !== {e_afu[d], e_blk[d], e_rdy[d], e_to[d]}) begin
                    n_bad++; $display("FAIL multi_model dut%0d step %0d: got %h want %h", d, s, {act_afu[d], act_blk[d], act_rdy[d], act_to[d]}, {e_afu[d], e_blk[d], e_rdy[d], e_to[d]});
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            for (int l = 0; l < NP; l++) begin
                if ($urandom_range(39) == 0) p_in[l] = ~p_in[l];
                vld[l] = 1'($urandom_range(1));
                rdy[l] = ($urandom_range(9) < 7);
                lst[l] = ($urandom_range(9) < ((i < 750) ? 3 : 1));
                clr[l] = ($urandom_range(19) == 0);
            end
            if (i == 1000) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            step();
            for (int d = 0; d < 2; d++) begin
                n_cmp++; if (act_afu[d] !== e_afu[d]) begin n_bad++; $display("FAIL rand_afu dut%0d cyc %0d: got %b want %b", d, i, act_afu[d], e_afu[d]); end
                n_cmp++; if (act_blk[d] !== e_blk[d]) begin n_bad++; $display("FAIL rand_blk dut%0d cyc %0d: got %b want %b", d, i, act_blk[d], e_blk[d]); end
                n_cmp++; if (act_rdy[d] !== e_rdy[d]) begin n_bad++; $display("FAIL rand_rdy dut%0d cyc %0d: got %b want %b", d, i, act_rdy[d], e_rdy[d]); end
                n_cmp++; if (act_to[d] !== e_to[d]) begin n_bad++; $display("FAIL rand_to dut%0d cyc %0d: got %b want %b", d, i, act_to[d], e_to[d]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_assert();
        test_open_packet();
        test_stuck_packet();
        test_hold_glitch();
        test_multi_lane();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/afu_port_rst_seq.md
Name: afu_port_rst_seq

Overview:
- Per-port reset sequencer for the PR region. It replaces the fixed two-flop port reset chain with a parametrised synchronizer, a release hold-off, and a drain-before-reset stage.
- Before asserting reset into the AFU workload, it waits for any in-flight TX A packet to complete, bounded by a timeout.
- It sits between the port gasket's port_rst_n and the AFU instances, one lane per PCIe port.

Parameters:
- NUM_PORTS, 1, number of independent port lanes.
- SYNC_STAGES, 2, synchronizer depth for port_rst_n_in; must be >= 2.
- HOLD_CYCLES, 16, cycles the AFU reset stays asserted after the request is released; must be >= 1.
- DRAIN_TIMEOUT, 1024, maximum cycles spent waiting for an open packet to close; must be >= 1.

Ports:
- clk  in  1  AFU clock; all logic is in this domain.
- rst_n  in  1  asynchronous, active-low reset for the whole block.
- port_rst_n_in  in  NUM_PORTS  per-port reset request, active-low; asynchronous to clk.
- tx_tvalid  in  NUM_PORTS  observed AFU TX A tvalid per port.
- tx_tready  in  NUM_PORTS  observed AFU TX A tready per port.
- tx_tlast  in  NUM_PORTS  observed AFU TX A tlast per port.
- timeout_clr  in  NUM_PORTS  single-cycle clear of drain_timeout.
- afu_port_rst_n  out  NUM_PORTS  active-low reset driven to the AFU workload.
- tx_block  out  NUM_PORTS  1 = upstream must not start a new TX A packet.
- port_rdy  out  NUM_PORTS  1 = lane in RUN.
- drain_timeout  out  NUM_PORTS  sticky flag: the last drain ended by timeout.

Behaviour:
- All lanes are identical and independent. Lane index i uses bit i of every vector.

Reset (rst_n low, async):
- Synchronizer flops = 0, state = RESET, in_pkt = 0, counter = 0, drain_timeout = 0.
- Outputs: afu_port_rst_n = 0, tx_block = 1, port_rdy = 0.

Synchronizer:
- SYNC_STAGES flops in series; req_n = last stage.
- No other logic samples port_rst_n_in directly.

Packet tracker (in_pkt):
- Set on tvalid & tready & ~tlast.
- Cleared on tvalid & tready & tlast.
- Forced to 0 while state is RESET or HOLD.
- A single-beat packet (tlast on the first beat) leaves in_pkt at 0.

FSM (Moore; outputs decoded from the state register):
- RESET: afu_port_rst_n = 0, tx_block = 1.
  - req_n = 1 -> HOLD, counter = HOLD_CYCLES-1.
- HOLD: afu_port_rst_n = 0, tx_block = 1.
  - req_n = 0 -> RESET.
  - Otherwise, counter = 0 -> RUN; else decrement.
  - HOLD therefore occupies exactly HOLD_CYCLES cycles.
- RUN: afu_port_rst_n = 1, tx_block = 0, port_rdy = 1.
  - req_n = 0 -> DRAIN, counter = DRAIN_TIMEOUT-1.
- DRAIN: afu_port_rst_n = 1, tx_block = 1, port_rdy = 0.
  - Registered in_pkt = 0 -> RESET.
  - Else counter = 0 -> RESET and set drain_timeout.
  - Else decrement.
  - req_n returning to 1 during DRAIN is ignored; the reset is committed.

Latency:
- Release: with port_rst_n_in high before clock edge 1 and held, afu_port_rst_n rises at edge SYNC_STAGES+HOLD_CYCLES+1.
- Assert, idle port: req_n falls at edge N -> DRAIN at N+1 -> RESET (afu_port_rst_n = 0) at N+2.
- Assert, open packet: RESET one edge after the edge on which the tlast beat is accepted, or after DRAIN_TIMEOUT cycles in DRAIN.

drain_timeout:
- Set wins over timeout_clr in the same cycle.
- Cleared only by timeout_clr or rst_n.

tx_block:
- Advisory only. This block does not gate data.
- Beats on an already-open packet continue to be counted in DRAIN.

Counter width is $clog2(max(HOLD_CYCLES, DRAIN_TIMEOUT)+1). It is shared between HOLD and DRAIN; no wrap is possible because it is always loaded on state entry.

Test Plan:
- Power-up, SYNC_STAGES=2, HOLD_CYCLES=16: hold rst_n low, then release with port_rst_n_in=1 -> outputs 0/1/0 during reset; afu_port_rst_n and port_rdy rise exactly 19 edges after the first sampling edge.
- Idle assert: in RUN, drop port_rst_n_in -> tx_block = 1 at edge 3 and afu_port_rst_n = 0 at edge 4; drain_timeout stays 0.
- Open packet, 4 beats, DRAIN_TIMEOUT=1024: request reset after beat 1 and accept beats 2-4 in DRAIN -> afu_port_rst_n falls one edge after the beat-4 tlast; drain_timeout = 0.
- Stuck packet, DRAIN_TIMEOUT=8: open a packet, stop tvalid, request reset -> RESET after exactly 8 DRAIN cycles; drain_timeout = 1 and stays 1 until timeout_clr, including when timeout_clr is asserted in the same cycle as the set.
- Glitch in HOLD: release the request, then re-assert it at HOLD cycle 5 -> lane returns to RESET with afu_port_rst_n never rising; a full 16-cycle HOLD restarts on the next release.
- NUM_PORTS=4: drive different reset timing per lane plus a global rst_n pulse mid-DRAIN on lane 2 -> lanes sequence independently; rst_n forces every lane to RESET asynchronously and clears drain_timeout.
